// File: rtl/atomic_pkg.sv
// atomic_pkg: shared encodings for the RV64A atomic sequencer.
// funct5 codes, FSM states and data-memory access sizes.
package atomic_pkg;

    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_SWAP = 5'b00001;
    localparam logic [4:0] F5_LR   = 5'b00010;
    localparam logic [4:0] F5_SC   = 5'b00011;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_AND  = 5'b01100;
    localparam logic [4:0] F5_MIN  = 5'b10000;
    localparam logic [4:0] F5_MAX  = 5'b10100;
    localparam logic [4:0] F5_MINU = 5'b11000;
    localparam logic [4:0] F5_MAXU = 5'b11100;

    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SC_CHECK,
        LD_REQ,
        LD_WAIT,
        ST_REQ,
        ST_WAIT,
        RESP
    } state_t;

    function automatic logic is_amo_op(input logic [4:0] f5);
        return f5 inside {F5_ADD, F5_SWAP, F5_XOR,
                          F5_OR, F5_AND, F5_MIN,
                          F5_MAX, F5_MINU, F5_MAXU};
    endfunction

endpackage

// File: rtl/amo_alu.sv
// amo_alu: combinational read-modify-write operator for AMOs.
// .W operands are sign-extended so 64-bit compares order them as 32-bit.
module amo_alu
    import atomic_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [4:0]      funct5,
    input  logic            is_word,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            lt_s;
    logic            lt_u;

    assign a = is_word ? {{(XLEN-32){old[31]}}, old[31:0]} : old;
    assign b = is_word ? {{(XLEN-32){rs2[31]}}, rs2[31:0]} : rs2;

    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;

    // operator select; non-AMO codes fall back to swap
    always_comb begin
        result = b;
        unique case (funct5)
            F5_ADD:  result = a + b;
            F5_SWAP: result = b;
            F5_XOR:  result = a ^ b;
            F5_OR:   result = a | b;
            F5_AND:  result = a & b;
            F5_MIN:  result = lt_s ? a : b;
            F5_MAX:  result = lt_s ? b : a;
            F5_MINU: result = lt_u ? a : b;
            F5_MAXU: result = lt_u ? b : a;
            default: result = b;
        endcase
    end

endmodule

// File: rtl/atomic_unit.sv
// atomic_unit: LR/SC/AMO sequencer between the LSU and data memory.
// ATOMIC_AMO_EN adds the AMO ALU and its store path; else LR/SC only.
module atomic_unit
    import atomic_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int NUM_HARTS  = 4,
    parameter int HART_W     = $clog2(NUM_HARTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [4:0]            req_funct5,
    input  logic                  req_is_word,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    input  logic [HART_W-1:0]     req_hart,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [XLEN-1:0]       resp_data,
    output logic                  resp_misaligned,
    output logic                  resp_illegal,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [XLEN-1:0]       mem_req_wdata,
    output logic [1:0]            mem_req_size,
    input  logic                  mem_resp_valid,
    input  logic [XLEN-1:0]       mem_resp_rdata,
    output logic [HART_W-1:0]     rsv_hart,
    output logic                  lr_valid,
    output logic                  lr_is_word,
    output logic [ADDR_WIDTH-1:0] lr_addr,
    output logic                  sc_valid,
    output logic                  sc_is_word,
    output logic [ADDR_WIDTH-1:0] sc_addr,
    input  logic                  sc_success
);

    state_t                state;
    state_t                state_nx;

    logic                  word_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [XLEN-1:0]       wdata_q;
    logic [XLEN-1:0]       data_q;
    logic [HART_W-1:0]     hart_q;
    logic                  mis_q;
    logic                  ill_q;

    logic                  is_lr_in;
    logic                  is_sc_in;
    logic                  legal_in;
    logic                  mis_in;
    logic                  accept;
    logic                  ld_is_lr;
    logic [XLEN-1:0]       ld_val;
    logic [XLEN-1:0]       st_raw;
    logic [XLEN-1:0]       st_val;

    assign is_lr_in = req_funct5 == F5_LR;
    assign is_sc_in = req_funct5 == F5_SC;
    assign accept   = (state == IDLE) && req_valid;

    assign mis_in = req_is_word ? (req_addr[1:0] != 2'b00)
                                : (req_addr[2:0] != 3'b000);

    assign ld_val = word_q
        ? {{(XLEN-32){mem_resp_rdata[31]}}, mem_resp_rdata[31:0]}
        : mem_resp_rdata;

`ifdef ATOMIC_AMO_EN
    logic [4:0]      f5_q;
    logic [XLEN-1:0] alu_res;

    assign legal_in = is_lr_in | is_sc_in | is_amo_op(req_funct5);
    assign ld_is_lr = f5_q == F5_LR;
    assign st_raw   = (f5_q == F5_SC) ? wdata_q : alu_res;

    // opcode is only needed once loads feed the ALU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) f5_q <= '0;
        else if (accept) f5_q <= req_funct5;
    end

    amo_alu #(.XLEN(XLEN)) u_alu (
        .funct5  (f5_q),
        .is_word (word_q),
        .old     (data_q),
        .rs2     (wdata_q),
        .result  (alu_res)
    );
`else
    assign legal_in = is_lr_in | is_sc_in;
    assign ld_is_lr = 1'b1;
    assign st_raw   = wdata_q;
`endif

    assign st_val = word_q ? {{(XLEN-32){1'b0}}, st_raw[31:0]}
                           : st_raw;

    // state register; reset abandons any outstanding access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state and handshake strobes
    always_comb begin
        state_nx      = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        lr_valid      = 1'b0;
        sc_valid      = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!legal_in || mis_in) state_nx = RESP;
                    else if (is_sc_in)       state_nx = SC_CHECK;
                    else                     state_nx = LD_REQ;
                end
            end
            SC_CHECK: begin
                sc_valid = 1'b1;
                state_nx = sc_success ? ST_REQ : RESP;
            end
            LD_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_nx = LD_WAIT;
            end
            LD_WAIT: begin
                if (mem_resp_valid) begin
                    lr_valid = ld_is_lr;
                    state_nx = ld_is_lr ? RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                if (mem_req_ready) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_resp_valid) state_nx = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // latch the request, then capture SC status or loaded data as rd
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hart_q  <= '0;
            mis_q   <= 1'b0;
            ill_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            if (accept) begin
                word_q  <= req_is_word;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                hart_q  <= req_hart;
                mis_q   <= legal_in & mis_in;
                ill_q   <= ~legal_in;
                data_q  <= '0;
            end
            if (state == SC_CHECK) begin
                data_q <= {{(XLEN-1){1'b0}}, ~sc_success};
            end
            if (state == LD_WAIT && mem_resp_valid) begin
                data_q <= ld_val;
            end
        end
    end

    assign resp_data       = data_q;
    assign resp_misaligned = resp_valid & mis_q;
    assign resp_illegal    = resp_valid & ill_q;

    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = mem_req_we ? st_val : '0;
    assign mem_req_size  = !mem_req_valid ? 2'b00
                         : (word_q ? SIZE_W : SIZE_D);

    assign rsv_hart   = hart_q;
    assign lr_addr    = addr_q;
    assign lr_is_word = lr_valid & word_q;
    assign sc_addr    = addr_q;
    assign sc_is_word = sc_valid & word_q;

endmodule

// File: tb/tb_atomic_unit.sv
// tb_atomic_unit: directed and random LR/SC/AMO sequences against a
// behavioural model of the atomic rules, with cycle-exact latency checks.
module tb_atomic_unit;

    localparam logic [4:0] ADD  = 5'b00000;
    localparam logic [4:0] SWAP = 5'b00001;
    localparam logic [4:0] LR   = 5'b00010;
    localparam logic [4:0] SC   = 5'b00011;
    localparam logic [4:0] XOR  = 5'b00100;
    localparam logic [4:0] OR   = 5'b01000;
    localparam logic [4:0] AND  = 5'b01100;
    localparam logic [4:0] MIN  = 5'b10000;
    localparam logic [4:0] MAX  = 5'b10100;
    localparam logic [4:0] MINU = 5'b11000;
    localparam logic [4:0] MAXU = 5'b11100;
    localparam logic [4:0] BAD  = 5'b00110;

`ifdef ATOMIC_AMO_EN
    localparam bit AMO_EN = 1'b1;
`else
    localparam bit AMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_funct5;
    logic        req_is_word;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_hart;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_misaligned;
    logic        resp_illegal;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [1:0]  mem_req_size;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic [1:0]  rsv_hart;
    logic        lr_valid;
    logic        lr_is_word;
    logic [63:0] lr_addr;
    logic        sc_valid;
    logic        sc_is_word;
    logic [63:0] sc_addr;
    logic        sc_success;

    int total = 0;
    int bad   = 0;

    logic [4:0]  ops [12] = '{ADD, SWAP, XOR, OR, AND, MIN, MAX,
                              MINU, MAXU, LR, SC, BAD};
    logic [4:0]  r_f5;
    logic        r_w;
    logic [63:0] r_addr;

    atomic_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_funct5      (req_funct5),
        .req_is_word     (req_is_word),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_hart        (req_hart),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_misaligned (resp_misaligned),
        .resp_illegal    (resp_illegal),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_we      (mem_req_we),
        .mem_req_addr    (mem_req_addr),
        .mem_req_wdata   (mem_req_wdata),
        .mem_req_size    (mem_req_size),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_rdata  (mem_resp_rdata),
        .rsv_hart        (rsv_hart),
        .lr_valid        (lr_valid),
        .lr_is_word      (lr_is_word),
        .lr_addr         (lr_addr),
        .sc_valid        (sc_valid),
        .sc_is_word      (sc_is_word),
        .sc_addr         (sc_addr),
        .sc_success      (sc_success)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    // value an AMO writes back, from the ISA rules in native integer types
    function automatic logic [63:0] amo_ref(input logic [4:0] f5,
                                            input bit w,
                                            input logic [63:0] old,
                                            input logic [63:0] rs2);
        int a32, b32;
        int unsigned u32, v32, r32;
        longint a64, b64;
        longint unsigned u64, v64, r64;
        a32 = old[31:0];
        b32 = rs2[31:0];
        u32 = old[31:0];
        v32 = rs2[31:0];
        a64 = old;
        b64 = rs2;
        u64 = old;
        v64 = rs2;
        r32 = v32;
        r64 = v64;
        case (f5)
            ADD:  begin r32 = u32 + v32; r64 = u64 + v64; end
            XOR:  begin r32 = u32 ^ v32; r64 = u64 ^ v64; end
            OR:   begin r32 = u32 | v32; r64 = u64 | v64; end
            AND:  begin r32 = u32 & v32; r64 = u64 & v64; end
            MIN:  begin
                r32 = (a32 < b32) ? u32 : v32;
                r64 = (a64 < b64) ? u64 : v64;
            end
            MAX:  begin
                r32 = (a32 > b32) ? u32 : v32;
                r64 = (a64 > b64) ? u64 : v64;
            end
            MINU: begin
                r32 = (u32 < v32) ? u32 : v32;
                r64 = (u64 < v64) ? u64 : v64;
            end
            MAXU: begin
                r32 = (u32 > v32) ? u32 : v32;
                r64 = (u64 > v64) ? u64 : v64;
            end
            default: begin r32 = v32; r64 = v64; end
        endcase
        return w ? {32'h0, r32} : r64;
    endfunction

    // issue one request, act as zero-wait memory, check the whole sequence
    task automatic run_op(input logic [4:0] f5, input bit w,
                          input logic [63:0] addr, input logic [63:0] rs2,
                          input logic [63:0] memval, input bit scs,
                          input logic [1:0] hart, input int hold);
        bit is_lr, is_sc, is_amo, ill, mis;
        bit pend, hs, done, seen, exp_we;
        int exp_cyc, exp_nreq, cyc, nreq, nlr, nsc, waited;
        logic [63:0] exp_rd, exp_st, mask, rd0;
        is_lr  = f5 == LR;
        is_sc  = f5 == SC;
        is_amo = AMO_EN && (f5 inside {ADD, SWAP, XOR, OR, AND,
                                       MIN, MAX, MINU, MAXU});
        ill    = !(is_lr || is_sc || is_amo);
        mis    = !ill && (w ? addr[1:0] != 0 : addr[2:0] != 0);
        mask   = w ? 64'h0000_0000_FFFF_FFFF : '1;
        exp_st = 64'h0;
        exp_rd = w ? sx32(memval) : memval;
        if (ill || mis) begin
            exp_cyc = 1; exp_nreq = 0;
        end else if (is_lr) begin
            exp_cyc = 3; exp_nreq = 1;
        end else if (is_sc) begin
            exp_cyc  = scs ? 4 : 2;
            exp_nreq = scs ? 1 : 0;
            exp_rd   = scs ? 64'd0 : 64'd1;
            exp_st   = rs2;
        end else begin
            exp_cyc = 5; exp_nreq = 2;
            exp_st  = amo_ref(f5, w, memval, rs2);
        end

        req_valid   = 1'b1;
        req_funct5  = f5;
        req_is_word = w;
        req_addr    = addr;
        req_wdata   = rs2;
        req_hart    = hart;
        sc_success  = scs;
        resp_ready  = 1'b0;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;

        cyc = 1; nreq = 0; nlr = 0; nsc = 0; waited = 0;
        pend = 0; hs = 0; done = 0; seen = 0; rd0 = '0;
        while (!done && cyc < 30) begin
            mem_resp_valid = pend;
            mem_resp_rdata = memval;
            #1;
            if (hs) begin
                chk("req_ready_after_resp", 64'(req_ready), 64'd1);
                chk("resp_valid_dropped", 64'(resp_valid), 64'd0);
                done = 1;
            end else begin
                pend = 0;
                if (mem_req_valid && mem_req_ready) begin
                    pend = 1;
                    nreq++;
                    exp_we = is_sc || nreq > 1;
                    chk("mem_we", 64'(mem_req_we), 64'(exp_we));
                    chk("mem_addr", mem_req_addr, addr);
                    chk("mem_size", 64'(mem_req_size), w ? 64'd2 : 64'd3);
                    if (mem_req_we)
                        chk("mem_wdata", mem_req_wdata & mask,
                            exp_st & mask);
                end
                if (lr_valid) begin
                    nlr++;
                    chk("lr_addr", lr_addr, addr);
                    chk("lr_is_word", 64'(lr_is_word), 64'(w));
                    chk("lr_hart", 64'(rsv_hart), 64'(hart));
                end
                if (sc_valid) begin
                    nsc++;
                    chk("sc_addr", sc_addr, addr);
                    chk("sc_is_word", 64'(sc_is_word), 64'(w));
                    chk("sc_hart", 64'(rsv_hart), 64'(hart));
                end
                chk("lr_sc_exclusive", 64'(lr_valid & sc_valid), 64'd0);
                chk("req_ready_busy", 64'(req_ready), 64'd0);
                if (resp_valid) begin
                    if (!seen) begin
                        seen = 1;
                        rd0  = resp_data;
                        chk("resp_cycle", 64'(cyc), 64'(exp_cyc));
                        chk("resp_misaligned", 64'(resp_misaligned),
                            64'(mis));
                        chk("resp_illegal", 64'(resp_illegal), 64'(ill));
                        if (!ill && !mis)
                            chk("resp_data", resp_data, exp_rd);
                    end else begin
                        chk("resp_data_stable", resp_data, rd0);
                    end
                    if (waited >= hold) begin
                        resp_ready = 1'b1;
                        hs = 1;
                    end
                    waited++;
                end
                @(posedge clk); #1;
                if (hs) resp_ready = 1'b0;
                cyc++;
            end
        end
        mem_resp_valid = 1'b0;
        resp_ready     = 1'b0;
        chk("handshake_done", 64'(done), 64'd1);
        chk("mem_req_count", 64'(nreq), 64'(exp_nreq));
        chk("lr_pulse_count", 64'(nlr), 64'(is_lr && !mis));
        chk("sc_pulse_count", 64'(nsc), 64'(is_sc && !mis));
    endtask

    initial begin
        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_funct5     = '0;
        req_is_word    = 1'b0;
        req_addr       = '0;
        req_wdata      = '0;
        req_hart       = '0;
        resp_ready     = 1'b0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        sc_success     = 1'b0;
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_mem_req_size", 64'(mem_req_size), 64'd0);
        chk("rst_lr_valid", 64'(lr_valid), 64'd0);
        chk("rst_sc_valid", 64'(sc_valid), 64'd0);
        chk("rst_flags", 64'({resp_misaligned, resp_illegal}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(LR, 0, 64'h1000, 64'h0, 64'h8000_0000_0000_0001, 0, 2'd1, 0);
        run_op(SC, 1, 64'h1004, 64'hDEAD_BEEF_1234_5678, 64'h0, 1, 2'd2, 0);
        run_op(SC, 1, 64'h1004, 64'hDEAD_BEEF_1234_5678, 64'h0, 0, 2'd2, 0);
        run_op(ADD, 1, 64'h2000, 64'h1, 64'h0000_0000_7FFF_FFFF, 0, 2'd0, 0);
        run_op(MINU, 0, 64'h2008, '1, 64'h1, 0, 2'd3, 0);
        run_op(MIN, 0, 64'h2008, '1, 64'h1, 0, 2'd3, 0);
        run_op(LR, 0, 64'h1004, 64'h0, 64'h55, 0, 2'd1, 0);
        run_op(BAD, 0, 64'h3000, 64'h7, 64'h9, 0, 2'd0, 0);
        run_op(MAXU, 1, 64'h3004, 64'h1, 64'hFFFF_FFFF_8000_0000, 0, 2'd2, 5);
        run_op(LR, 1, 64'h3008, 64'h0, 64'h1234_5678_9ABC_DEF0, 0, 2'd3, 5);

        // reset while waiting for load data, then a stale response
        req_valid   = 1'b1;
        req_funct5  = LR;
        req_is_word = 1'b0;
        req_addr    = 64'h4000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        chk("midrst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hCAFE;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stale_resp_valid", 64'(resp_valid), 64'd0);
            chk("stale_lr_valid", 64'(lr_valid), 64'd0);
            chk("stale_req_ready", 64'(req_ready), 64'd1);
            chk("stale_mem_req", 64'(mem_req_valid), 64'd0);
        end
        mem_resp_valid = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 60; i++) begin
            r_f5   = ops[$urandom_range(0, 11)];
            r_w    = 1'($urandom_range(0, 1));
            r_addr = 64'($urandom_range(0, 4095)) << 3;
            if ($urandom_range(0, 7) == 0)
                r_addr = r_addr + 64'($urandom_range(1, 7));
            else if (r_w && $urandom_range(0, 1) == 1)
                r_addr = r_addr + 64'd4;
            run_op(r_f5, r_w, r_addr, {$urandom, $urandom},
                   {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
